// File: rtl/anita3_event_writer_if.sv
// -----------------------------------------------------------------------------
// anita3_event_writer_if
//   Valid/ready event-word stream feeding the ANITA3 event writer.
//
//   Handshake: a word transfers on a rising clk33_i edge where evt_valid and
//   evt_ready are both high. The source holds evt_dat/evt_last stable while
//   evt_valid is high and not yet accepted. evt_last marks the final word of
//   one event.
//
//   Signals
//     evt_dat    16  event data word                (source -> writer)
//     evt_valid   1  evt_dat valid                  (source -> writer)
//     evt_last    1  evt_dat is final word of event (source -> writer)
//     evt_ready   1  writer can accept this cycle   (writer -> source)
//
//   Modports: master = word source, slave = event writer.
// -----------------------------------------------------------------------------
interface anita3_event_writer_if;
   logic [15:0] evt_dat;
   logic        evt_valid;
   logic        evt_last;
   logic        evt_ready;

   modport master (output evt_dat, output evt_valid, output evt_last, input evt_ready);
   modport slave  (input evt_dat, input evt_valid, input evt_last, output evt_ready);
endinterface

// File: rtl/anita3_event_writer.sv
// -----------------------------------------------------------------------------
// anita3_event_writer
//   Write-side producer for the 4-deep ANITA3 event buffer RAM (4 x 64 x 16b).
//   Each incoming event is written into the next free buffer, then
//   event_done_o pulses so the reader marks that buffer active. Buffer
//   occupancy is tracked against clear_evt_i; new events are refused while
//   all four buffers are full.
//
//   Optional feature macro: EVENT_WRITER_HEADER_EN
//     When defined, word 0 of every buffer holds a header
//     {4'hE, wr_buf[1:0], evt_num[9:0]} and the payload starts at word 1.
//
//   Parameters
//     MAX_WORDS        words stored per event (1..64); extra words are dropped
//
//   Ports
//     clk33_i          in   1   system clock
//     rst_n_i          in   1   asynchronous reset, active-low
//     evt              slave    event word stream (anita3_event_writer_if)
//     event_wr_addr_o  out  8   {buffer[1:0], word[5:0]} RAM write address
//     event_wr_dat_o   out  16  RAM write data
//     event_wr_o       out  1   RAM write strobe, one cycle per word
//     event_done_o     out  1   1-cycle pulse, addr[7:6] = completed buffer
//     clear_evt_i      in   1   1-cycle pulse: reader released oldest buffer
//     write_buffer_o   out  2   buffer being / next to be written
//     buffers_full_o   out  1   occupancy == 4
//     status_o         out  32  {16'h0, trunc_cnt, 2'b0, state, 1'b0, occupancy}
//
//   All outputs are registered; a word accepted on edge n shows up as a RAM
//   write during the following cycle. event_done_o is high during the DONE
//   state, i.e. together with the final write of a non-truncated event.
// -----------------------------------------------------------------------------
module anita3_event_writer #(
   parameter int MAX_WORDS = 64
) (
   input  logic                  clk33_i,
   input  logic                  rst_n_i,
   anita3_event_writer_if.slave  evt,
   output logic [7:0]            event_wr_addr_o,
   output logic [15:0]           event_wr_dat_o,
   output logic                  event_wr_o,
   output logic                  event_done_o,
   input  logic                  clear_evt_i,
   output logic [1:0]            write_buffer_o,
   output logic                  buffers_full_o,
   output logic [31:0]           status_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      DISCARD = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(MAX_WORDS - 1);

   state_t      state_q, state_d;
   logic [1:0]  wr_buf_q, wr_buf_d;
   logic [5:0]  word_q, word_d;     // index of the most recently written word
   logic [2:0]  occ_q, occ_d;
   logic [7:0]  trunc_q, trunc_d;
   logic        ready_d, wr_d, done_d;
   logic [7:0]  addr_d;
   logic [15:0] dat_d;
   logic        accept, inc, dec;
   logic        take;               // a payload word is to be written in WRITE
   logic [15:0] w_dat;
   logic        w_last;
   logic [5:0]  nxt_idx;
   logic [7:0]  trunc_sat;

`ifdef EVENT_WRITER_HEADER_EN
   // The first accepted word is parked here while the header occupies word 0.
   logic        pend_q, pend_d;
   logic [15:0] pend_dat_q, pend_dat_d;
   logic        pend_last_q, pend_last_d;
   logic [9:0]  evt_num_q, evt_num_d;
`endif

   assign accept    = evt.evt_valid & evt.evt_ready;
   assign nxt_idx   = word_q + 6'd1;
   assign trunc_sat = (trunc_q == 8'hFF) ? trunc_q : trunc_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      wr_buf_d = wr_buf_q;
      word_d   = word_q;
      trunc_d  = trunc_q;
      wr_d     = 1'b0;
      addr_d   = event_wr_addr_o;   // holds the last written address
      dat_d    = event_wr_dat_o;
      inc      = 1'b0;
      take     = accept;
      w_dat    = evt.evt_dat;
      w_last   = evt.evt_last;
`ifdef EVENT_WRITER_HEADER_EN
      pend_d      = pend_q;
      pend_dat_d  = pend_dat_q;
      pend_last_d = pend_last_q;
      evt_num_d   = evt_num_q;
      if (pend_q) begin
         take   = 1'b1;
         w_dat  = pend_dat_q;
         w_last = pend_last_q;
      end
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_d   = 1'b1;
               word_d = 6'd0;
               addr_d = {wr_buf_q, 6'd0};
`ifdef EVENT_WRITER_HEADER_EN
               dat_d = {4'hE, wr_buf_q, evt_num_q};
               if (LAST_IDX == 6'd0) begin
                  // No room for payload at all: the whole event is truncated.
                  if (evt.evt_last) begin
                     state_d = DONE;
                     trunc_d = trunc_sat;
                  end else begin
                     state_d = DISCARD;
                  end
               end else begin
                  pend_d      = 1'b1;
                  pend_dat_d  = evt.evt_dat;
                  pend_last_d = evt.evt_last;
                  state_d     = WRITE;
               end
`else
               dat_d = evt.evt_dat;
               if (evt.evt_last)
                  state_d = DONE;
               else if (LAST_IDX == 6'd0)
                  state_d = DISCARD;
               else
                  state_d = WRITE;
`endif
            end
         end

         WRITE: begin
            if (take) begin
`ifdef EVENT_WRITER_HEADER_EN
               pend_d = 1'b0;
`endif
               wr_d   = 1'b1;
               word_d = nxt_idx;
               addr_d = {wr_buf_q, nxt_idx};
               dat_d  = w_dat;
               if (w_last)
                  state_d = DONE;
               else if (nxt_idx == LAST_IDX)
                  state_d = DISCARD;
            end
         end

         DISCARD: begin
            if (accept && evt.evt_last) begin
               state_d = DONE;
               trunc_d = trunc_sat;
            end
         end

         DONE: begin
            inc      = 1'b1;
            state_d  = IDLE;
            wr_buf_d = wr_buf_q + 2'd1;
            word_d   = 6'd0;
`ifdef EVENT_WRITER_HEADER_EN
            evt_num_d = evt_num_q + 10'd1;
`endif
         end

         default: state_d = IDLE;
      endcase

      // A release with nothing held is ignored; done plus release cancel out.
      dec   = clear_evt_i && (occ_q != 3'd0);
      occ_d = occ_q + {2'b00, inc} - {2'b00, dec};

      done_d = (state_d == DONE);

      // Ready is registered, so it is derived from the next-cycle state.
      case (state_d)
         IDLE:    ready_d = (occ_d < 3'd4);
`ifdef EVENT_WRITER_HEADER_EN
         WRITE:   ready_d = !pend_d;
`else
         WRITE:   ready_d = 1'b1;
`endif
         DISCARD: ready_d = 1'b1;
         default: ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk33_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q         <= IDLE;
         wr_buf_q        <= 2'd0;
         word_q          <= 6'd0;
         occ_q           <= 3'd0;
         trunc_q         <= 8'd0;
         evt.evt_ready   <= 1'b0;
         event_wr_addr_o <= 8'd0;
         event_wr_dat_o  <= 16'd0;
         event_wr_o      <= 1'b0;
         event_done_o    <= 1'b0;
         write_buffer_o  <= 2'd0;
         buffers_full_o  <= 1'b0;
         status_o        <= 32'd0;
`ifdef EVENT_WRITER_HEADER_EN
         pend_q          <= 1'b0;
         pend_dat_q      <= 16'd0;
         pend_last_q     <= 1'b0;
         evt_num_q       <= 10'd0;
`endif
      end else begin
         state_q         <= state_d;
         wr_buf_q        <= wr_buf_d;
         word_q          <= word_d;
         occ_q           <= occ_d;
         trunc_q         <= trunc_d;
         evt.evt_ready   <= ready_d;
         event_wr_addr_o <= addr_d;
         event_wr_dat_o  <= dat_d;
         event_wr_o      <= wr_d;
         event_done_o    <= done_d;
         write_buffer_o  <= wr_buf_d;
         buffers_full_o  <= (occ_d == 3'd4);
         status_o        <= {16'h0, trunc_d, 2'b00, state_d, 1'b0, occ_d};
`ifdef EVENT_WRITER_HEADER_EN
         pend_q          <= pend_d;
         pend_dat_q      <= pend_dat_d;
         pend_last_q     <= pend_last_d;
         evt_num_q       <= evt_num_d;
`endif
      end
   end

endmodule

// File: tb/tb_anita3_event_writer.sv
// -----------------------------------------------------------------------------
// tb_anita3_event_writer
//   Directed bench for anita3_event_writer (default build, MAX_WORDS = 64).
//   Stimulus tasks push the expected RAM writes and done addresses into
//   queues; a negedge monitor pops and compares whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_anita3_event_writer;
   localparam int MAXW = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_evt = 1'b0;
   logic [7:0]  event_wr_addr;
   logic [15:0] event_wr_dat;
   logic        event_wr;
   logic        event_done;
   logic [1:0]  write_buffer;
   logic        buffers_full;
   logic [31:0] status;

   anita3_event_writer_if evt_if ();

   anita3_event_writer #(.MAX_WORDS(MAXW)) dut (
      .clk33_i         (clk),
      .rst_n_i         (rst_n),
      .evt             (evt_if),
      .event_wr_addr_o (event_wr_addr),
      .event_wr_dat_o  (event_wr_dat),
      .event_wr_o      (event_wr),
      .event_done_o    (event_done),
      .clear_evt_i     (clear_evt),
      .write_buffer_o  (write_buffer),
      .buffers_full_o  (buffers_full),
      .status_o        (status)
   );

   // ---------------- clock / reset ----------------
   always #15 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [23:0] exp_q[$];        // {addr, dat} of expected RAM writes
   logic [7:0]  exp_done_q[$];   // expected event_done_o addresses
   logic [1:0]  m_buf = 2'd0;    // bench's idea of the buffer being filled

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_buf = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, {31'd0, evt_if.evt_ready}, 32'd0);
      chk({tag, "_wr"},    {31'd0, event_wr}, 32'd0);
      chk({tag, "_done"},  {31'd0, event_done}, 32'd0);
      chk({tag, "_addr"},  {24'd0, event_wr_addr}, 32'd0);
      chk({tag, "_dat"},   {16'd0, event_wr_dat}, 32'd0);
      chk({tag, "_wbuf"},  {30'd0, write_buffer}, 32'd0);
      chk({tag, "_full"},  {31'd0, buffers_full}, 32'd0);
      chk({tag, "_status"}, status, 32'd0);
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_word(input logic [15:0] d, input bit last);
      int t = 0;
      evt_if.evt_dat   = d;
      evt_if.evt_valid = 1'b1;
      evt_if.evt_last  = last;
      @(negedge clk);
      while (!evt_if.evt_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!evt_if.evt_ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout actual=0 expected=1 word=%0h", d);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_event(input int n, input logic [15:0] base, input bit with_last);
      int stored;
      stored = (n < MAXW) ? n : MAXW;
      for (int i = 0; i < n; i++)
         if (i < MAXW) exp_q.push_back({m_buf, 6'(i), 16'(base + 16'(i))});
      if (with_last) exp_done_q.push_back({m_buf, 6'(stored - 1)});
      for (int i = 0; i < n; i++)
         send_word(16'(base + 16'(i)), with_last && (i == n - 1));
      evt_if.evt_valid = 1'b0;
      evt_if.evt_last  = 1'b0;
      if (with_last) m_buf = m_buf + 2'd1;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear_evt = 1'b1;
      @(posedge clk); #1;
      clear_evt = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [23:0] exp_w;
   logic [7:0]  exp_d;
   always @(negedge clk) begin
      if (rst_n) begin
         if (event_wr) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected actual=%0h expected=none", {event_wr_addr, event_wr_dat});
            end else begin
               exp_w = exp_q.pop_front();
               chk("ram_write", {8'd0, event_wr_addr, event_wr_dat}, {8'd0, exp_w});
            end
         end
         if (event_done) begin
            if (exp_done_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL done_unexpected actual=%0h expected=none", event_wr_addr);
            end else begin
               exp_d = exp_done_q.pop_front();
               chk("done_addr", {24'd0, event_wr_addr}, {24'd0, exp_d});
            end
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      evt_if.evt_dat   = 16'd0;
      evt_if.evt_valid = 1'b0;
      evt_if.evt_last  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      do_reset();
      chk("ready_after_reset", {31'd0, evt_if.evt_ready}, 32'd1);

      // Four-word event A0..A3 into buffer 0
      send_event(4, 16'h00A0, 1'b1);
      settle();
      chk("t1_wbuf", {30'd0, write_buffer}, 32'd1);
      chk("t1_status", status, 32'h0000_0001);

      // Fill all four buffers, then a fifth event waits for a release
      do_reset();
      for (int e = 0; e < 4; e++) send_event(2, 16'(16'h1000 + 16'(e * 16)), 1'b1);
      settle();
      chk("t2_full", {31'd0, buffers_full}, 32'd1);
      chk("t2_ready", {31'd0, evt_if.evt_ready}, 32'd0);
      chk("t2_status", status, 32'h0000_0004);
      chk("t2_wbuf", {30'd0, write_buffer}, 32'd0);
      fork
         send_event(2, 16'h1500, 1'b1);
         begin
            repeat (6) @(posedge clk);
            @(negedge clk);
            chk("t2_blocked_ready", {31'd0, evt_if.evt_ready}, 32'd0);
            chk("t2_blocked_queue", exp_q.size(), 32'd2);
            pulse_clear();
         end
      join
      settle();
      chk("t2_refill_status", status, 32'h0000_0004);
      chk("t2_refill_full", {31'd0, buffers_full}, 32'd1);
      chk("t2_refill_wbuf", {30'd0, write_buffer}, 32'd1);

      // Drain; a release at occupancy 0 is ignored
      repeat (4) pulse_clear();
      settle();
      chk("drain_status", status, 32'h0000_0000);
      chk("drain_full", {31'd0, buffers_full}, 32'd0);
      pulse_clear();
      settle();
      chk("clear_at_zero", status, 32'h0000_0000);

      // Release coincident with done at occupancy 2
      send_event(1, 16'h2000, 1'b1);
      send_event(1, 16'h2100, 1'b1);
      settle();
      chk("t4_pre_status", status, 32'h0000_0002);
      fork
         send_event(3, 16'h3000, 1'b1);
         begin
            int t = 0;
            @(negedge clk);
            while (!event_done && t < 200) begin
               @(negedge clk);
               t++;
            end
            chk("t4_done_seen", {31'd0, event_done}, 32'd1);
            clear_evt = 1'b1;
            @(posedge clk); #1;
            clear_evt = 1'b0;
         end
      join
      settle();
      chk("t4_status", status, 32'h0000_0002);
      chk("t4_wbuf", {30'd0, write_buffer}, 32'd0);

      // 70-word event truncated to 64 stored words in buffer 0
      send_event(70, 16'h4000, 1'b1);
      settle();
      chk("t3_status", status, 32'h0000_0103);
      chk("t3_wbuf", {30'd0, write_buffer}, 32'd1);

      // Reset after 10 words of an event: nothing completes, buffer 0 next
      send_event(10, 16'h5000, 1'b0);
      repeat (2) @(posedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      m_buf = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_event(3, 16'h6000, 1'b1);
      settle();
      chk("t5_status", status, 32'h0000_0001);
      chk("t5_wbuf", {30'd0, write_buffer}, 32'd1);

      // Everything expected was observed
      settle();
      chk("writes_drained", exp_q.size(), 32'd0);
      chk("dones_drained", exp_done_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
